// File: rtl/cplx_add_arbiter.sv
// cplx_add_arbiter
// Shares one two-stage pipelined complex adder among NUM_REQ requesters.
// A round-robin arbiter grants at most one requester per cycle. Stage 1
// registers the winning operands and id. Stage 2 registers the sum and id
// and presents them downstream through a valid/ready handshake.
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   req_valid  per-requester operand-pair valid
//   req_ready  one-hot grant; high only for the requester accepted this cycle
//   req_a      operand A, requester i at [i*2*DW +: 2*DW]
//   req_b      operand B, same packing as req_a
//   res_valid  result valid
//   res_ready  downstream accepts the result
//   res_data   complex sum: real in [2*DW-1:DW], imag in [DW-1:0]
//   res_id     index of the requester that produced res_data
//   busy       either pipeline stage holds a valid entry
//
// Build option: define CPLX_ARB_SAT_EN to make each component saturate on
// signed overflow. Without it, each component wraps modulo 2^DW. Latency is
// the same in both builds.
module cplx_add_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 16
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [NUM_REQ-1:0]                  req_valid,
  output logic [NUM_REQ-1:0]                  req_ready,
  input  logic [NUM_REQ*2*DATA_WIDTH-1:0]     req_a,
  input  logic [NUM_REQ*2*DATA_WIDTH-1:0]     req_b,
  output logic                                res_valid,
  input  logic                                res_ready,
  output logic [2*DATA_WIDTH-1:0]             res_data,
  output logic [$clog2(NUM_REQ)-1:0]          res_id,
  output logic                                busy
);

  localparam int DW  = DATA_WIDTH;
  localparam int CW  = 2 * DATA_WIDTH;
  localparam int IDW = $clog2(NUM_REQ);

  logic           s1_valid_q;
  logic [CW-1:0]  s1_a_q;
  logic [CW-1:0]  s1_b_q;
  logic [IDW-1:0] s1_id_q;
  logic           res_valid_q;
  logic [CW-1:0]  res_data_q;
  logic [IDW-1:0] res_id_q;
  logic [IDW-1:0] rr_ptr_q;
  logic [IDW-1:0] rr_ptr_d;

  logic               s1_en;
  logic               s2_en;
  logic               grant_found;
  logic [IDW-1:0]     grant_id;
  logic [IDW-1:0]     cand;
  logic [NUM_REQ-1:0] grant_oh;
  logic               accept;
  logic [CW-1:0]      sum_d;

  assign s2_en = !res_valid_q || res_ready;
  assign s1_en = !s1_valid_q || s2_en;

  // Rotating priority: the scan starts just after the last winner, so the
  // last winner has the lowest priority.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    cand        = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDW'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_id    = cand;
      end
    end
  end

  // The grant is qualified by rst_n so that req_ready stays low while reset
  // is asserted, even though stage 1 then appears empty.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_grant
    assign grant_oh[gi] = rst_n && s1_en && grant_found && (grant_id == IDW'(gi));
  end

  assign req_ready = grant_oh;
  assign accept    = |grant_oh;
  assign rr_ptr_d  = accept ? grant_id : rr_ptr_q;

  // One component add. The sum is sign-extended by one bit, so a signed
  // overflow shows up as a mismatch between the top two bits.
  function automatic logic [DW-1:0] add_comp(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW:0] ext;
    ext = {a[DW-1], a} + {b[DW-1], b};
`ifdef CPLX_ARB_SAT_EN
    if (ext[DW] != ext[DW-1]) begin
      return ext[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    end
`endif
    return ext[DW-1:0];
  endfunction

  assign sum_d = {add_comp(s1_a_q[CW-1:DW], s1_b_q[CW-1:DW]),
                  add_comp(s1_a_q[DW-1:0],  s1_b_q[DW-1:0])};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_id_q     <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_id_q    <= '0;
      rr_ptr_q    <= IDW'(NUM_REQ - 1);
    end else begin
      rr_ptr_q <= rr_ptr_d;
      if (s1_en) begin
        s1_valid_q <= accept;
        if (accept) begin
          s1_a_q  <= req_a[grant_id*CW +: CW];
          s1_b_q  <= req_b[grant_id*CW +: CW];
          s1_id_q <= grant_id;
        end
      end
      if (s2_en) begin
        res_valid_q <= s1_valid_q;
        res_data_q  <= sum_d;
        res_id_q    <= s1_id_q;
      end
    end
  end

  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_id    = res_id_q;
  assign busy      = s1_valid_q | res_valid_q;

endmodule

// File: tb/tb_cplx_add_arbiter.sv
// Testbench for cplx_add_arbiter (NUM_REQ=4, DATA_WIDTH=16).
// The reference model keeps an ordered queue of accepted transfers, each
// carrying its arithmetic sum, requester id and acceptance cycle. The model
// also keeps the index of the last winner, from which the rotating grant is
// derived.
module tb_cplx_add_arbiter;
  localparam int NR = 4;
  localparam int DW = 16;
  localparam int CW = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NR-1:0]    req_valid;
  logic [NR-1:0]    req_ready;
  logic [NR*CW-1:0] req_a;
  logic [NR*CW-1:0] req_b;
  logic             res_valid;
  logic             res_ready;
  logic [CW-1:0]    res_data;
  logic [1:0]       res_id;
  logic             busy;

  cplx_add_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_id(res_id),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [CW-1:0] data;
    int            id;
    int            t;
  } item_t;

  item_t         q[$];
  int            cyc    = 0;
  int            last_w = NR - 1;
  int            exp_w;
  logic [NR-1:0] exp_ready;
  logic          exp_rv;
  logic          exp_busy;
  logic [CW-1:0] exp_data;
  logic [1:0]    exp_id;

  function automatic logic [CW-1:0] ref_sum(input logic [CW-1:0] a, input logic [CW-1:0] b);
    int re, im;
    logic [31:0] ru, iu;
    re = int'($signed(a[CW-1:DW])) + int'($signed(b[CW-1:DW]));
    im = int'($signed(a[DW-1:0]))  + int'($signed(b[DW-1:0]));
`ifdef CPLX_ARB_SAT_EN
    if (re > 32767)  re = 32767;
    if (re < -32768) re = -32768;
    if (im > 32767)  im = 32767;
    if (im < -32768) im = -32768;
`endif
    ru = re;
    iu = im;
    return {ru[DW-1:0], iu[DW-1:0]};
  endfunction

  // Expectations for the current cycle, computed after the inputs settle.
  // At most two transfers can be in flight. A transfer's result is visible
  // two cycles after acceptance, provided it is at the head of the order.
  task automatic model_expect();
    bit found;
    int idx;
    found = 0;
    exp_w = 0;
    for (int k = 1; k <= NR; k++) begin
      idx = (last_w + k) % NR;
      if (!found && req_valid[idx]) begin
        found = 1;
        exp_w = idx;
      end
    end
    exp_ready = '0;
    if (found && (q.size() < 2 || res_ready)) exp_ready[exp_w] = 1'b1;
    exp_rv   = (q.size() > 0) && (cyc >= q[0].t + 2);
    exp_busy = (q.size() > 0);
    exp_data = '0;
    exp_id   = '0;
    if (q.size() > 0) begin
      exp_data = q[0].data;
      exp_id   = 2'(q[0].id);
    end
  endtask

  task automatic model_commit();
    if (exp_rv && res_ready) void'(q.pop_front());
    if (exp_ready != '0) begin
      item_t it;
      it.data = ref_sum(req_a[exp_w*CW +: CW], req_b[exp_w*CW +: CW]);
      it.id   = exp_w;
      it.t    = cyc;
      q.push_back(it);
      last_w = exp_w;
    end
    cyc++;
  endtask

  task automatic model_reset();
    q.delete();
    last_w = NR - 1;
  endtask

  task automatic settle();
    #2;
    model_expect();
  endtask

  task automatic edge_step();
    model_commit();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [CW-1:0] a, input logic [CW-1:0] b);
    req_a[i*CW +: CW] = a;
    req_b[i*CW +: CW] = b;
  endtask

  task automatic rand_op(input int i);
    set_op(i, $urandom, $urandom);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    req_valid = '1;
    res_ready = 1'b1;
    for (int i = 0; i < NR; i++) rand_op(i);
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (req_ready !== 4'b0000) $display("FAIL reset_req_ready got=%b exp=0000", req_ready); else n_pass++;
    n_checks++; if (res_valid !== 1'b0) $display("FAIL reset_res_valid got=%b exp=0", res_valid); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else n_pass++;
    n_checks++; if (res_data !== 32'h0) $display("FAIL reset_res_data got=%h exp=0", res_data); else n_pass++;
    n_checks++; if (res_id !== 2'd0) $display("FAIL reset_res_id got=%0d exp=0", res_id); else n_pass++;
    req_valid = '0;
    rst_n     = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    do_reset();
    res_ready = 1'b1;
    req_valid = 4'b0001;
    set_op(0, {16'd3, 16'd4}, {16'd10, 16'hFFFE});
    settle();
    n_checks++; if (req_ready !== 4'b0001) $display("FAIL single_grant got=%b exp=0001", req_ready); else n_pass++;
    edge_step();
    req_valid = '0;
    settle();
    n_checks++; if (res_valid !== 1'b0) $display("FAIL single_early_valid got=%b exp=0", res_valid); else n_pass++;
    edge_step();
    settle();
    n_checks++; if (res_valid !== 1'b1) $display("FAIL single_valid_T2 got=%b exp=1", res_valid); else n_pass++;
    n_checks++; if (res_data !== {16'd13, 16'd2}) $display("FAIL single_data got=%h exp=%h", res_data, {16'd13, 16'd2}); else n_pass++;
    n_checks++; if (res_id !== 2'd0) $display("FAIL single_id got=%0d exp=0", res_id); else n_pass++;
    edge_step();
    settle();
    n_checks++; if (res_valid !== 1'b0) $display("FAIL single_after got=%b exp=0", res_valid); else n_pass++;
    edge_step();
  endtask

  task automatic test_round_robin();
    logic [NR-1:0] oh;
    do_reset();
    res_ready = 1'b1;
    for (int i = 0; i < NR; i++) rand_op(i);
    for (int k = 0; k < 10; k++) begin
      req_valid = (k < 8) ? 4'b1111 : 4'b0000;
      settle();
      if (k < 8) begin
        oh = '0;
        oh[k % NR] = 1'b1;
        n_checks++; if (req_ready !== oh) $display("FAIL rr_grant k=%0d got=%b exp=%b", k, req_ready, oh); else n_pass++;
      end
      n_checks++; if (res_valid !== (k >= 2)) $display("FAIL rr_res_valid k=%0d got=%b exp=%b", k, res_valid, (k >= 2)); else n_pass++;
      if (k >= 2) begin
        n_checks++; if (res_id !== 2'((k - 2) % NR)) $display("FAIL rr_res_id k=%0d got=%0d exp=%0d", k, res_id, (k - 2) % NR); else n_pass++;
        n_checks++; if (res_data !== exp_data) $display("FAIL rr_res_data k=%0d got=%h exp=%h", k, res_data, exp_data); else n_pass++;
      end
      edge_step();
      if (k < 8) rand_op(k % NR);
    end
  endtask

  task automatic test_backpressure();
    logic [NR-1:0] acc;
    do_reset();
    rand_op(2);
    for (int k = 0; k < 18; k++) begin
      req_valid = (k < 9) ? 4'b0100 : 4'b0000;
      res_ready = !(k >= 3 && k <= 5);
      settle();
      n_checks++; if (req_ready !== exp_ready) $display("FAIL bp_req_ready k=%0d got=%b exp=%b", k, req_ready, exp_ready); else n_pass++;
      n_checks++; if (res_valid !== exp_rv) $display("FAIL bp_res_valid k=%0d got=%b exp=%b", k, res_valid, exp_rv); else n_pass++;
      n_checks++; if (busy !== exp_busy) $display("FAIL bp_busy k=%0d got=%b exp=%b", k, busy, exp_busy); else n_pass++;
      if (exp_rv) begin
        n_checks++; if (res_data !== exp_data) $display("FAIL bp_res_data k=%0d got=%h exp=%h", k, res_data, exp_data); else n_pass++;
        n_checks++; if (res_id !== exp_id) $display("FAIL bp_res_id k=%0d got=%0d exp=%0d", k, res_id, exp_id); else n_pass++;
      end
      acc = exp_ready;
      edge_step();
      if (acc[2]) rand_op(2);
    end
    n_checks++; if (busy !== 1'b0) $display("FAIL bp_drained_busy got=%b exp=0", busy); else n_pass++;
  endtask

  task automatic test_overflow();
    logic [CW-1:0] exp_ovf;
`ifdef CPLX_ARB_SAT_EN
    exp_ovf = {16'h7FFF, 16'h8000};
`else
    exp_ovf = {16'h8000, 16'h7FFF};
`endif
    do_reset();
    res_ready = 1'b1;
    req_valid = 4'b0001;
    set_op(0, {16'h7FFF, 16'h8000}, {16'h0001, 16'hFFFF});
    settle();
    edge_step();
    req_valid = '0;
    settle();
    edge_step();
    settle();
    n_checks++; if (res_valid !== 1'b1) $display("FAIL ovf_valid got=%b exp=1", res_valid); else n_pass++;
    n_checks++; if (res_data !== exp_ovf) $display("FAIL ovf_data got=%h exp=%h", res_data, exp_ovf); else n_pass++;
    n_checks++; if (res_data !== exp_data) $display("FAIL ovf_model got=%h exp=%h", res_data, exp_data); else n_pass++;
    edge_step();
  endtask

  task automatic test_reset_midflight();
    do_reset();
    res_ready = 1'b0;
    req_valid = 4'b0001;
    rand_op(0);
    settle();
    edge_step();
    req_valid = 4'b0010;
    rand_op(1);
    settle();
    edge_step();
    req_valid = '0;
    rst_n = 1'b0;
    #1;
    n_checks++; if (res_valid !== 1'b0) $display("FAIL mid_rst_valid got=%b exp=0", res_valid); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL mid_rst_busy got=%b exp=0", busy); else n_pass++;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    res_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      settle();
      n_checks++; if (res_valid !== 1'b0) $display("FAIL mid_stale_valid k=%0d got=%b exp=0", k, res_valid); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL mid_stale_busy k=%0d got=%b exp=0", k, busy); else n_pass++;
      edge_step();
    end
    req_valid = 4'b1001;
    rand_op(0);
    rand_op(3);
    settle();
    n_checks++; if (req_ready !== 4'b0001) $display("FAIL mid_first_grant got=%b exp=0001", req_ready); else n_pass++;
    edge_step();
    req_valid = 4'b1000;
    settle();
    n_checks++; if (req_ready !== 4'b1000) $display("FAIL mid_second_grant got=%b exp=1000", req_ready); else n_pass++;
    edge_step();
    req_valid = '0;
    repeat (3) begin
      settle();
      edge_step();
    end
  endtask

  task automatic test_pointer_hold();
    do_reset();
    res_ready = 1'b0;
    req_valid = 4'b0001;
    rand_op(0);
    settle();
    edge_step();
    rand_op(0);
    settle();
    edge_step();
    req_valid = 4'b1010;
    rand_op(1);
    rand_op(3);
    for (int k = 0; k < 3; k++) begin
      settle();
      n_checks++; if (req_ready !== 4'b0000) $display("FAIL hold_stall k=%0d got=%b exp=0000", k, req_ready); else n_pass++;
      n_checks++; if (res_data !== exp_data) $display("FAIL hold_res_data k=%0d got=%h exp=%h", k, res_data, exp_data); else n_pass++;
      edge_step();
    end
    res_ready = 1'b1;
    settle();
    n_checks++; if (req_ready !== 4'b0010) $display("FAIL hold_release got=%b exp=0010", req_ready); else n_pass++;
    edge_step();
    req_valid = 4'b1000;
    settle();
    n_checks++; if (req_ready !== 4'b1000) $display("FAIL hold_next got=%b exp=1000", req_ready); else n_pass++;
    edge_step();
    req_valid = '0;
    repeat (4) begin
      settle();
      if (exp_rv) begin
        n_checks++; if (res_id !== exp_id) $display("FAIL hold_drain_id got=%0d exp=%0d", res_id, exp_id); else n_pass++;
      end
      edge_step();
    end
  endtask

  task automatic test_random();
    logic [NR-1:0] acc;
    do_reset();
    for (int c = 0; c < 320; c++) begin
      for (int i = 0; i < NR; i++) begin
        if (c < 300 && !req_valid[i] && ($urandom_range(1, 0) == 1)) begin
          req_valid[i] = 1'b1;
          rand_op(i);
        end
      end
      res_ready = (c >= 300) || ($urandom_range(3, 0) != 0);
      settle();
      n_checks++; if (req_ready !== exp_ready) $display("FAIL rnd_req_ready c=%0d got=%b exp=%b", c, req_ready, exp_ready); else n_pass++;
      n_checks++; if (res_valid !== exp_rv) $display("FAIL rnd_res_valid c=%0d got=%b exp=%b", c, res_valid, exp_rv); else n_pass++;
      n_checks++; if (busy !== exp_busy) $display("FAIL rnd_busy c=%0d got=%b exp=%b", c, busy, exp_busy); else n_pass++;
      if (exp_rv) begin
        n_checks++; if (res_data !== exp_data) $display("FAIL rnd_res_data c=%0d got=%h exp=%h", c, res_data, exp_data); else n_pass++;
        n_checks++; if (res_id !== exp_id) $display("FAIL rnd_res_id c=%0d got=%0d exp=%0d", c, res_id, exp_id); else n_pass++;
      end
      acc = exp_ready;
      edge_step();
      req_valid = req_valid & ~acc;
    end
    n_checks++; if (busy !== 1'b0) $display("FAIL rnd_drained_busy got=%b exp=0", busy); else n_pass++;
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    res_ready = 1'b1;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_overflow();
    test_reset_midflight();
    test_pointer_hold();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
